// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side (fetch, LSU data) and memory-side
// signals of the shared memory port.
// master: arbiter view (drives acks, read data, memory request bus, err, stall).
// slave : environment view (requesters plus memory model).
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // fetch requester
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_ack;
  logic [DW-1:0]   if_rdata;
  // data requester
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_bmask;
  logic            d_ack;
  logic [DW-1:0]   d_rdata;
  // memory side
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_bmask;
  logic            mem_ready;
  logic [DW-1:0]   mem_rdata;
  // status
  logic            err;
  logic            stall;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_bmask,
           mem_ready, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_bmask, err, stall
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_bmask,
           mem_ready, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_bmask, err, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, variable-latency memory between
// the instruction-fetch path and the LSU data path. Data wins over fetch when
// both request in IDLE. Each access runs IDLE -> FETCH/DATA -> RESP, so the
// best case is one access every three cycles.
// Optional feature macro: MEM_PORT_ARBITER_TIMEOUT_EN -- when defined, an
// access that sees no mem_ready for TIMEOUT wait cycles is ended with zero
// read data and an err pulse alongside the ack.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  mem_port_arbiter_if.master io_bus
);

  localparam int BW = DW / 8;

  // A non-positive TIMEOUT or a data width that is not whole bytes cannot be
  // built into a meaningful port; this empty marker block flags such a setup.
  if ((TIMEOUT < 1) || ((DW % 8) != 0)) begin : g_cfg_invalid
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_mem_req,   w_mem_req_nxt;
  logic            r_mem_we,    w_mem_we_nxt;
  logic [AW-1:0]   r_mem_addr,  w_mem_addr_nxt;
  logic [DW-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic [BW-1:0]   r_mem_bmask, w_mem_bmask_nxt;
  logic            r_if_ack,    w_if_ack_nxt;
  logic [DW-1:0]   r_if_rdata,  w_if_rdata_nxt;
  logic            r_d_ack,     w_d_ack_nxt;
  logic [DW-1:0]   r_d_rdata,   w_d_rdata_nxt;

  logic            w_timeout;
  logic            w_done;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_err, w_err_nxt;

  // Give up on the memory once the saturated wait count hits TIMEOUT.
  assign w_timeout = (r_cnt == CNT_MAX);

  // Wait counter: counts while an access is in flight, saturates, cleared otherwise.
  always_comb begin
    w_cnt_nxt = r_cnt;
    case (r_state)
      ST_FETCH, ST_DATA: begin
        if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CW'(1'b1);
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      default: w_cnt_nxt = {CW{1'b0}};
    endcase
  end

  // err is raised only when the access ended by timeout; a late ready wins.
  always_comb begin
    w_err_nxt = 1'b0;
    case (r_state)
      ST_FETCH, ST_DATA: begin
        if (w_timeout && !io_bus.mem_ready) begin
          w_err_nxt = 1'b1;
        end else begin
          w_err_nxt = 1'b0;
        end
      end
      default: w_err_nxt = 1'b0;
    endcase
  end

  // Wait counter and err pulse registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= {CW{1'b0}};
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign io_bus.err = r_err;
`else
  // Without the timeout the port simply waits for the memory forever.
  assign w_timeout  = 1'b0;
  assign io_bus.err = 1'b0;
`endif

  assign w_done = io_bus.mem_ready | w_timeout;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: grant in IDLE with data priority, finish on ready/timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.d_req) begin
          w_state_nxt = ST_DATA;
        end else if (io_bus.if_req) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FETCH, ST_DATA: begin
        if (w_done) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: next values for the memory bus, read-data and ack registers.
  always_comb begin
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_bmask_nxt = r_mem_bmask;
    w_if_rdata_nxt  = r_if_rdata;
    w_d_rdata_nxt   = r_d_rdata;
    w_if_ack_nxt    = 1'b0;
    w_d_ack_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.d_req) begin
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = io_bus.d_we;
          w_mem_addr_nxt  = io_bus.d_addr;
          w_mem_wdata_nxt = io_bus.d_wdata;
          w_mem_bmask_nxt = io_bus.d_bmask;
        end else if (io_bus.if_req) begin
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = io_bus.if_addr;
          w_mem_bmask_nxt = {BW{1'b0}};
        end else begin
          w_mem_req_nxt   = 1'b0;
        end
      end
      ST_FETCH: begin
        if (w_done) begin
          w_mem_req_nxt  = 1'b0;
          w_if_ack_nxt   = 1'b1;
          w_if_rdata_nxt = io_bus.mem_ready ? io_bus.mem_rdata : {DW{1'b0}};
        end else begin
          w_mem_req_nxt  = 1'b1;
        end
      end
      ST_DATA: begin
        if (w_done) begin
          w_mem_req_nxt = 1'b0;
          w_d_ack_nxt   = 1'b1;
          // Stores and timed-out loads return zero.
          w_d_rdata_nxt = (io_bus.mem_ready && !r_mem_we) ? io_bus.mem_rdata
                                                          : {DW{1'b0}};
        end else begin
          w_mem_req_nxt = 1'b1;
        end
      end
      ST_RESP: w_mem_req_nxt = 1'b0;
      default: w_mem_req_nxt = 1'b0;
    endcase
  end

  // Registered outputs toward memory and requesters.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {AW{1'b0}};
      r_mem_wdata <= {DW{1'b0}};
      r_mem_bmask <= {BW{1'b0}};
      r_if_ack    <= 1'b0;
      r_if_rdata  <= {DW{1'b0}};
      r_d_ack     <= 1'b0;
      r_d_rdata   <= {DW{1'b0}};
    end else begin
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_bmask <= w_mem_bmask_nxt;
      r_if_ack    <= w_if_ack_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_d_ack     <= w_d_ack_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
    end
  end

  assign io_bus.mem_req   = r_mem_req;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign io_bus.mem_bmask = r_mem_bmask;
  assign io_bus.if_ack    = r_if_ack;
  assign io_bus.if_rdata  = r_if_rdata;
  assign io_bus.d_ack     = r_d_ack;
  assign io_bus.d_rdata   = r_d_rdata;

  // The PC must freeze as soon as a request appears, before it is granted.
  assign io_bus.stall = (r_state != ST_IDLE) | io_bus.if_req | io_bus.d_req;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plus randomized accesses against a
// transaction-level expectation (owner, bus contents, ack cycle, read data).
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic [31:0] rdata;
    int          waits;
    bit          drop_early;
  } acc_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) u_dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .io_bus(bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One access, called in the IDLE cycle whose closing edge grants it.
  task automatic run_access(input acc_t a, output int ack_cyc);
    logic [31:0] exp_rd;
    int          start;
    exp_rd = (a.is_data && a.we) ? 32'h0 : a.rdata;
    start  = cyc;
    tick();
    for (int w = 0; w <= a.waits; w++) begin
      chk("mem_req_hi", bus.mem_req, 1'b1);
      chk("mem_addr", bus.mem_addr, a.addr);
      chk("mem_we", bus.mem_we, a.is_data ? a.we : 1'b0);
      chk("mem_bmask", bus.mem_bmask, a.is_data ? a.bmask : 4'h0);
      if (a.is_data) chk("mem_wdata", bus.mem_wdata, a.wdata);
      chk("no_early_ack", {bus.if_ack, bus.d_ack}, 2'b00);
      chk("stall_busy", bus.stall, 1'b1);
      // Owner's inputs change after the grant; the access must not notice.
      if (a.is_data) begin
        bus.d_addr  = $urandom();
        bus.d_wdata = $urandom();
        bus.d_bmask = 4'($urandom_range(0, 15));
        bus.d_we    = 1'($urandom_range(0, 1));
        if (a.drop_early) bus.d_req = 1'b0;
      end else begin
        bus.if_addr = $urandom();
        if (a.drop_early) bus.if_req = 1'b0;
      end
      bus.mem_ready = (w == a.waits);
      bus.mem_rdata = (w == a.waits) ? a.rdata : $urandom();
      tick();
    end
    ack_cyc = cyc;
    chk("latency", ack_cyc - start, 2 + a.waits);
    chk("ack_owner", a.is_data ? bus.d_ack : bus.if_ack, 1'b1);
    chk("ack_other", a.is_data ? bus.if_ack : bus.d_ack, 1'b0);
    chk("rdata", a.is_data ? bus.d_rdata : bus.if_rdata, exp_rd);
    chk("err_clear", bus.err, 1'b0);
    chk("mem_req_drop", bus.mem_req, 1'b0);
    if (a.is_data) bus.d_req = 1'b0; else bus.if_req = 1'b0;
    bus.mem_ready = 1'($urandom_range(0, 1));  // ignored in RESP
    bus.mem_rdata = $urandom();
    tick();
    bus.mem_ready = 1'b0;
    chk("ack_one_cycle", {bus.if_ack, bus.d_ack}, 2'b00);
    chk("rdata_hold", a.is_data ? bus.d_rdata : bus.if_rdata, exp_rd);
  endtask

  initial begin
    acc_t a, b;
    int   t0, t1, n_hi;
    bit   all_hi, any_ack;

    rst_n = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_bmask = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    tick(); tick();
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_acks", {bus.if_ack, bus.d_ack, bus.err}, 3'b000);
    chk("rst_rdata", {bus.if_rdata, bus.d_rdata}, 64'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_stall", bus.stall, 1'b0);

    // Zero-wait fetch.
    bus.if_req = 1'b1; bus.if_addr = 32'h4;
    #1 chk("stall_on_req", bus.stall, 1'b1);
    a = '{is_data:0, we:0, addr:32'h4, wdata:0, bmask:0, rdata:32'h00500093, waits:0, drop_early:0};
    run_access(a, t0);
    chk("stall_after_fetch", bus.stall, 1'b0);

    // Simultaneous requests: data first, fetch three cycles after d_ack.
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2000; bus.d_wdata = 32'h0; bus.d_bmask = 4'hF;
    a = '{is_data:1, we:0, addr:32'h2000, wdata:0, bmask:4'hF, rdata:32'h12345678, waits:0, drop_early:0};
    b = '{is_data:0, we:0, addr:32'h100, wdata:0, bmask:0, rdata:32'hCAFEF00D, waits:0, drop_early:0};
    run_access(a, t0);
    chk("stall_fetch_pending", bus.stall, 1'b1);
    run_access(b, t1);
    chk("fetch_after_data", t1 - t0, 3);

    // Store with three wait cycles.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h3000;
    bus.d_wdata = 32'hDEADBEEF; bus.d_bmask = 4'b0011;
    a = '{is_data:1, we:1, addr:32'h3000, wdata:32'hDEADBEEF, bmask:4'b0011,
          rdata:32'h55AA55AA, waits:3, drop_early:0};
    run_access(a, t0);

    // Spurious ready in IDLE.
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("spurious_no_ack", {bus.if_ack, bus.d_ack, bus.mem_req}, 3'b000);
      chk("spurious_stall", bus.stall, 1'b0);
    end
    bus.mem_ready = 1'b0;

    // Randomized traffic; the model grants data ahead of fetch.
    for (int it = 0; it < 40; it++) begin
      int pat;
      pat = $urandom_range(1, 3);
      a.is_data = 1'b1; a.we = 1'($urandom_range(0, 1)); a.addr = $urandom();
      a.wdata = $urandom(); a.bmask = 4'($urandom_range(0, 15));
      a.rdata = $urandom(); a.waits = $urandom_range(0, 3); a.drop_early = 1'($urandom_range(0, 1));
      b.is_data = 1'b0; b.we = 1'b0; b.addr = $urandom(); b.wdata = 0; b.bmask = 0;
      b.rdata = $urandom(); b.waits = $urandom_range(0, 3); b.drop_early = 1'($urandom_range(0, 1));
      if (pat[1]) begin
        bus.d_req = 1'b1; bus.d_we = a.we; bus.d_addr = a.addr;
        bus.d_wdata = a.wdata; bus.d_bmask = a.bmask;
      end
      if (pat[0]) begin
        bus.if_req = 1'b1; bus.if_addr = b.addr;
      end
      if (pat[1]) run_access(a, t0);
      if (pat[0]) run_access(b, t1);
      if (pat == 3) chk("rand_order", t1 - t0, 3 + b.waits);
      chk("rand_idle_stall", bus.stall, 1'b0);
    end

    // Reset in the middle of a data wait.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h4000;
    tick(); tick();
    chk("pre_reset_req", bus.mem_req, 1'b1);
    rst_n = 1'b0;
    #1 chk("reset_drops_req", bus.mem_req, 1'b0);
    chk("reset_clears_rdata", {bus.if_rdata, bus.d_rdata}, 64'h0);
    bus.d_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    any_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      any_ack = any_ack | bus.d_ack | bus.if_ack;
    end
    chk("reset_no_ack", any_ack, 1'b0);
    chk("reset_outputs", {bus.mem_req, bus.mem_we, bus.mem_bmask, bus.err, bus.stall}, 8'h00);
    chk("reset_mem_addr", bus.mem_addr, 32'h0);

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    // Fetch that the memory never answers.
    a = '{is_data:0, we:0, addr:32'h80, wdata:0, bmask:0, rdata:32'hFFFFFFFF, waits:0, drop_early:0};
    bus.if_req = 1'b1; bus.if_addr = 32'h80;
    run_access(a, t0);
    bus.if_req = 1'b1; bus.if_addr = 32'h84;
    tick();
    n_hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.mem_req) break;
      n_hi++;
      tick();
    end
    chk("timeout_req_cycles", n_hi, TMO + 1);
    chk("timeout_ack", bus.if_ack, 1'b1);
    chk("timeout_err", bus.err, 1'b1);
    chk("timeout_rdata", bus.if_rdata, 32'h0);
    bus.if_req = 1'b0;
    tick();
    chk("timeout_err_pulse", {bus.err, bus.if_ack}, 2'b00);
`else
    // Without the timeout the port waits on the memory indefinitely.
    bus.if_req = 1'b1; bus.if_addr = 32'h84;
    tick();
    all_hi = 1'b1; any_ack = 1'b0;
    for (int i = 0; i < 110; i++) begin
      all_hi  = all_hi & bus.mem_req;
      any_ack = any_ack | bus.if_ack | bus.d_ack | bus.err;
      tick();
    end
    chk("no_timeout_req", all_hi, 1'b1);
    chk("no_timeout_ack", any_ack, 1'b0);
    bus.if_req = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("recover_idle", {bus.mem_req, bus.stall}, 2'b00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between the instruction-fetch path and the LSU data path of the RISC-V core.
- Sequences each access with a req/ready handshake toward memory and a req/ack handshake toward each requester.
- Drives a stall output that freezes the PC register while a fetch or data access is outstanding.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8.
- TIMEOUT, 255, maximum wait cycles for mem_ready (used only when the optional feature is enabled).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  AW  fetch address.
- if_ack  out  1  one-cycle pulse; if_rdata valid in that cycle.
- if_rdata  out  DW  fetched instruction.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_bmask  in  DW/8  store byte enables.
- d_ack  out  1  one-cycle pulse; d_rdata valid in that cycle.
- d_rdata  out  DW  load data (0 for stores).
- mem_req  out  1  memory access request (registered).
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_bmask  out  DW/8  memory byte enables.
- mem_ready  in  1  memory completion; read data is valid on mem_rdata in the same cycle.
- mem_rdata  in  DW  memory read data.
- err  out  1  one-cycle pulse alongside an ack that ended in timeout.
- stall  out  1  high whenever a request is pending or an access is in flight.

Behaviour:
- Reset (rst = 0, async) clears every output to 0, puts the FSM in IDLE and clears the wait counter. Reset mid-transaction drops mem_req immediately; the aborted access produces no ack.
- FSM states and transitions:
  - IDLE: if d_req, latch the d_* inputs into the mem_* registers, set mem_req = 1, go to DATA. Else if if_req, latch if_addr, set mem_we = 0 and mem_bmask = 0, set mem_req = 1, go to FETCH.
  - FETCH / DATA: hold mem_* stable and increment the wait counter each cycle. On mem_ready: clear mem_req, capture mem_rdata into the owner's rdata register, go to RESP.
  - RESP: pulse the owner's ack for exactly 1 cycle, clear the counter, return to IDLE. A new grant is decided in the IDLE cycle that follows.
- Priority: d_req beats if_req when both are high in IDLE. The core cannot issue back-to-back data accesses without an intervening fetch, so fetch cannot starve.
- Latency with zero-wait memory (mem_ready high in the first FETCH/DATA cycle): request seen at cycle N, mem_req high at N+1, ack at N+2. Each wait cycle adds 1. Best-case throughput is one access per 3 cycles.
- mem_ready seen in IDLE or RESP is ignored.
- Store: d_rdata = 0 at d_ack.
- The rdata outputs hold their last value between acks.
- A requester that drops req mid-access still gets its ack pulse; the access is not cancelled.
- Inputs change only at IDLE grant time; later changes to if_addr or d_* do not affect the access in flight.
- stall = (state != IDLE) | if_req | d_req, combinational; it is 0 only when IDLE with no request.
- Wait counter is $clog2(TIMEOUT+1) bits and saturates; it never wraps.

Optional Feature:
- Macro: MEM_PORT_ARBITER_TIMEOUT_EN.
- Enabled: if the counter reaches TIMEOUT in FETCH/DATA without mem_ready, clear mem_req and go to RESP with the owner's rdata = 0 and err pulsed together with the ack.
- Disabled: the FSM waits indefinitely, err is tied to 0, and the counter is not instantiated.

Test Plan:
- Zero-wait fetch: if_req = 1, if_addr = 0x00000004, memory returns 0x00500093 with mem_ready in the first cycle -> mem_req high at N+1 with mem_addr = 0x4; if_ack pulse at N+2 with if_rdata = 0x00500093; stall falls to 0 after if_req drops.
- Simultaneous requests: if_req = d_req = 1, d_we = 0, d_addr = 0x2000 -> DATA granted first with mem_addr = 0x2000, d_ack first; FETCH is then granted and if_ack arrives at least 3 cycles after d_ack.
- Store with 3 wait cycles: d_we = 1, d_wdata = 0xDEADBEEF, d_bmask = 4'b0011 -> mem_we, mem_wdata and mem_bmask stay stable for 4 cycles; d_ack pulse with d_rdata = 0; total latency 5 cycles.
- Reset mid-access: assert rst = 0 during DATA wait -> mem_req = 0 immediately with no clock edge; no d_ack; after release, state is IDLE and all outputs are 0.
- Timeout (macro on, TIMEOUT = 4): fetch with mem_ready never asserted -> mem_req drops after 4 wait cycles; if_ack and err pulse together with if_rdata = 0. With the macro off, mem_req stays high and no ack occurs for more than 100 cycles.
- Spurious ready: mem_ready = 1 while IDLE -> no ack, no state change, stall = 0.
